fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 10, number of storage slots (>=2); need not be a power of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0; 0 = registered read mode, 1 = first-word-fall-through mode.
REQ-006 Derived widths: PW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 flush  input  1  synchronous clear of FIFO contents.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read/pop request.
REQ-012 data_in  input  WIDTH  write data.
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 data_out  output  WIDTH  read data.
REQ-015 full / empty  output  1 each  count==DEPTH / count==0, combinational from count.
REQ-016 almost_full / almost_empty  output  1 each  count>=AF_LEVEL / count<=AE_LEVEL, combinational.
REQ-017 count  output  CW  current occupancy, 0..DEPTH.
REQ-018 write_ptr / read_ptr  output  PW each  slot indices, for status display.
REQ-019 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-020 Write accepted (wr_ok) when wr_en && (!full || rd_ok); rd_ok = rd_en && !empty.
REQ-021 Accepted write stores data_in at mem[write_ptr]; write_ptr advances, wrapping DEPTH-1 -> 0.
REQ-022 Accepted read advances read_ptr, wrapping DEPTH-1 -> 0.
REQ-023 count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-024 Full with wr_en && rd_en: both accepted, count stays DEPTH, oldest word popped, new word stored in freed slot.
REQ-025 Empty with wr_en && rd_en: write accepted, read rejected, count -> 1; no bypass of data_in to data_out.
REQ-026 FWFT=0: on rd_ok, data_out <= mem[read_ptr] (1-cycle latency); data_out holds otherwise.
REQ-027 FWFT=1: data_out = mem[read_ptr] continuously; valid whenever !empty; rd_ok pops, next word visible the following cycle; value when empty is don't-care.
REQ-028 overflow sets on wr_en && !wr_ok; underflow sets on rd_en && empty; both hold until err_clr.
REQ-029 err_clr clears both flags the next edge; a same-cycle set condition wins over err_clr.
REQ-030 flush: next edge sets write_ptr, read_ptr, count to 0 and (FWFT=0) data_out to 0; overrides wr_en/rd_en that cycle; memory contents unchanged; error flags unchanged.
REQ-031 Rejected operations change no pointer, count, memory or data_out.

Reset
REQ-032 reset asserted: immediately write_ptr=0, read_ptr=0, count=0, data_out=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-033 Memory array not reset; reads only return words written after reset/flush.
REQ-034 Reset mid-operation discards all stored words; first edge after deassertion behaves as empty FIFO.

Verification (WIDTH=8, DEPTH=10, defaults unless noted)
REQ-035 Write 0x01..0x0A, then 10 reads (FWFT=0) -> data_out 0x01..0x0A in order, each 1 cycle after rd_en; full=1 after 10th write, empty=1 after 10th read; almost_full at count 8, almost_empty at count 2.
REQ-036 Wrap: 7 writes, 7 reads, 10 writes 0x20..0x29 -> write_ptr wraps 9->0, reads return 0x20..0x29, count 10->0.
REQ-037 Full + wr_en + rd_en with data_in 0xAA -> data_out = oldest word, count stays 10, overflow stays 0; 0xAA read out last.
REQ-038 wr_en at full (no rd_en) -> count 10, memory unchanged, overflow=1 until err_clr; rd_en at empty -> underflow=1, data_out unchanged; err_clr with simultaneous rd_en at empty -> underflow stays 1.
REQ-039 FWFT=1: write 0x55 -> data_out=0x55 next cycle with empty=0; rd_en pops, empty=1 next cycle.
REQ-040 5 writes then flush with wr_en=1 -> count=0, empty=1, pointers 0, overflow unchanged; async reset asserted mid-burst -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/fifo_param.sv
// Synchronous FIFO with arbitrary depth, sticky overflow/underflow flags,
// synchronous flush and either registered or first-word-fall-through read data.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic [PW-1:0]    write_ptr,
    output logic [PW-1:0]    read_ptr,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] write_ptr_q, write_ptr_d;
    logic [PW-1:0] read_ptr_q,  read_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_ok, rd_ok;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ok       = rd_en && !empty && !flush;
        wr_ok       = wr_en && (!full || rd_ok) && !flush;
        write_ptr_d = write_ptr_q;
        read_ptr_d  = read_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            write_ptr_d = '0;
            read_ptr_d  = '0;
            count_d     = '0;
        end else begin
            if (wr_ok) write_ptr_d = ptr_inc(write_ptr_q);
            if (rd_ok) read_ptr_d  = ptr_inc(read_ptr_q);
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A set condition in the same cycle takes precedence over the clear.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && wr_en && !wr_ok) overflow_d  = 1'b1;
        if (!flush && rd_en && empty)  underflow_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_ptr_q <= '0;
            read_ptr_q  <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            write_ptr_q <= write_ptr_d;
            read_ptr_q  <= read_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy tracking guarantees stale words are never presented.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[write_ptr_q] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = mem_q[read_ptr_q];
    end else begin : g_reg_out
        logic [WIDTH-1:0] data_out_q, data_out_d;

        always_comb begin
            data_out_d = data_out_q;
            if (flush)      data_out_d = '0;
            else if (rd_ok) data_out_d = mem_q[read_ptr_q];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) data_out_q <= '0;
            else       data_out_q <= data_out_d;
        end

        assign data_out = data_out_q;
    end

    assign count     = count_q;
    assign write_ptr = write_ptr_q;
    assign read_ptr  = read_ptr_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: registered-read instance for most scenarios,
// a second first-word-fall-through instance for the FWFT behaviour.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush, wr_en, rd_en, err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic [3:0] write_ptr, read_ptr;
    logic       overflow, underflow;

    logic       f_flush, f_wr_en, f_rd_en, f_err_clr;
    logic [7:0] f_data_in;
    logic [7:0] f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty;
    logic [3:0] f_count;
    logic [3:0] f_write_ptr, f_read_ptr;
    logic       f_overflow, f_underflow;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(10), .FWFT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .err_clr(err_clr), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .write_ptr(write_ptr), .read_ptr(read_ptr),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.WIDTH(8), .DEPTH(10), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .flush(f_flush), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .data_in(f_data_in), .err_clr(f_err_clr), .data_out(f_data_out),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .write_ptr(f_write_ptr), .read_ptr(f_read_ptr),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // One clock on the registered-read instance; strobes drop again after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_en = w; rd_en = r; data_in = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic f_step(input logic w, input logic r, input logic [7:0] d);
        f_wr_en = w; f_rd_en = r; f_data_in = d;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    // status = {empty, full, almost_empty, almost_full, overflow, underflow}
    task automatic test_reset;
        reset = 1'b1;
        flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; data_in = 0;
        f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_err_clr = 0; f_data_in = 0;
        #12;
        total++;
        if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000)
            $display("FAIL reset_status: got %b expected 101000",
                     {empty, full, almost_empty, almost_full, overflow, underflow});
        else passed++;
        total++;
        if ({count, write_ptr, read_ptr, data_out} !== 20'h0)
            $display("FAIL reset_state: got count=%0d wp=%0d rp=%0d dout=%h expected all 0",
                     count, write_ptr, read_ptr, data_out);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 8'(i));
            total++;
            if ({count, full, almost_full, almost_empty, empty} !==
                {4'(i), i == 10, i >= 8, i <= 2, 1'b0})
                $display("FAIL fill[%0d]: got count=%0d full=%b af=%b ae=%b empty=%b expected count=%0d full=%b af=%b ae=%b empty=0",
                         i, count, full, almost_full, almost_empty, empty, i, i == 10, i >= 8, i <= 2);
            else passed++;
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if ({data_out, count, empty, full} !== {8'(i), 4'(10 - i), i == 10, 1'b0})
                $display("FAIL drain[%0d]: got dout=%h count=%0d empty=%b full=%b expected dout=%h count=%0d empty=%b full=0",
                         i, data_out, count, empty, full, i, 10 - i, i == 10);
            else passed++;
        end
        total++;
        if ({write_ptr, read_ptr} !== 8'h00)
            $display("FAIL drain_ptrs: got wp=%0d rp=%0d expected 0 0", write_ptr, read_ptr);
        else passed++;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 8'h1F + 8'(k));
            total++;
            if ({write_ptr, count} !== {4'((7 + k) % 10), 4'(k)})
                $display("FAIL wrap_wr[%0d]: got wp=%0d count=%0d expected wp=%0d count=%0d",
                         k, write_ptr, count, (7 + k) % 10, k);
            else passed++;
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if ({data_out, read_ptr, count} !== {8'h1F + 8'(k), 4'((7 + k) % 10), 4'(10 - k)})
                $display("FAIL wrap_rd[%0d]: got dout=%h rp=%0d count=%0d expected dout=%h rp=%0d count=%0d",
                         k, data_out, read_ptr, count, 8'h1F + 8'(k), (7 + k) % 10, 10 - k);
            else passed++;
        end
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h31 + 8'(i));
        step(1'b1, 1'b1, 8'hAA);
        total++;
        if ({data_out, count, full, overflow} !== {8'h31, 4'd10, 1'b1, 1'b0})
            $display("FAIL full_rw: got dout=%h count=%0d full=%b ovf=%b expected dout=31 count=10 full=1 ovf=0",
                     data_out, count, full, overflow);
        else passed++;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== ((i == 10) ? 8'hAA : 8'h31 + 8'(i)))
                $display("FAIL full_rw_drain[%0d]: got dout=%h expected %h",
                         i, data_out, (i == 10) ? 8'hAA : 8'h31 + 8'(i));
            else passed++;
        end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        step(1'b1, 1'b0, 8'hEE);
        total++;
        if ({count, overflow, underflow} !== {4'd10, 1'b1, 1'b0})
            $display("FAIL overflow_set: got count=%0d ovf=%b unf=%b expected count=10 ovf=1 unf=0",
                     count, overflow, underflow);
        else passed++;
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (overflow !== 1'b1)
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== 8'h40 + 8'(i))
                $display("FAIL overflow_mem[%0d]: got dout=%h expected %h", i, data_out, 8'h40 + 8'(i));
            else passed++;
        end
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, count, underflow} !== {8'h49, 4'd0, 1'b1})
            $display("FAIL underflow_set: got dout=%h count=%0d unf=%b expected dout=49 count=0 unf=1",
                     data_out, count, underflow);
        else passed++;
        err_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        total++;
        if ({overflow, underflow} !== 2'b00)
            $display("FAIL err_clr: got ovf=%b unf=%b expected 0 0", overflow, underflow);
        else passed++;
        err_clr = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (underflow !== 1'b1)
            $display("FAIL err_clr_vs_set: got unf=%b expected 1", underflow);
        else passed++;
        err_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        // Write and read together on an empty FIFO: write only, no bypass.
        step(1'b1, 1'b1, 8'h77);
        total++;
        if ({data_out, count, underflow} !== {8'h49, 4'd1, 1'b1})
            $display("FAIL empty_rw: got dout=%h count=%0d unf=%b expected dout=49 count=1 unf=1",
                     data_out, count, underflow);
        else passed++;
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {8'h77, 1'b1})
            $display("FAIL empty_rw_read: got dout=%h empty=%b expected dout=77 empty=1", data_out, empty);
        else passed++;
    endtask

    task automatic test_flush;
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        flush = 1'b1;
        step(1'b1, 1'b0, 8'hBB);
        total++;
        if ({count, empty, write_ptr, read_ptr, data_out} !== {4'd0, 1'b1, 4'd0, 4'd0, 8'h00})
            $display("FAIL flush_state: got count=%0d empty=%b wp=%0d rp=%0d dout=%h expected 0 1 0 0 00",
                     count, empty, write_ptr, read_ptr, data_out);
        else passed++;
        total++;
        if ({overflow, underflow} !== 2'b01)
            $display("FAIL flush_flags: got ovf=%b unf=%b expected 0 1", overflow, underflow);
        else passed++;
        step(1'b1, 1'b0, 8'h88);
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {8'h88, 1'b1})
            $display("FAIL flush_reuse: got dout=%h empty=%b expected dout=88 empty=1", data_out, empty);
        else passed++;
        err_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_fwft;
        f_step(1'b1, 1'b0, 8'h55);
        total++;
        if ({f_data_out, f_empty} !== {8'h55, 1'b0})
            $display("FAIL fwft_first: got dout=%h empty=%b expected dout=55 empty=0", f_data_out, f_empty);
        else passed++;
        f_step(1'b1, 1'b0, 8'h66);
        total++;
        if ({f_data_out, f_count} !== {8'h55, 4'd2})
            $display("FAIL fwft_hold: got dout=%h count=%0d expected dout=55 count=2", f_data_out, f_count);
        else passed++;
        f_step(1'b0, 1'b1, 8'h00);
        total++;
        if ({f_data_out, f_empty} !== {8'h66, 1'b0})
            $display("FAIL fwft_pop: got dout=%h empty=%b expected dout=66 empty=0", f_data_out, f_empty);
        else passed++;
        f_step(1'b0, 1'b1, 8'h00);
        total++;
        if ({f_empty, f_count} !== {1'b1, 4'd0})
            $display("FAIL fwft_empty: got empty=%b count=%0d expected empty=1 count=0", f_empty, f_count);
        else passed++;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        wr_en = 1'b1; data_in = 8'hFF;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({count, write_ptr, read_ptr, data_out} !== 20'h0)
            $display("FAIL async_reset_state: got count=%0d wp=%0d rp=%0d dout=%h expected all 0",
                     count, write_ptr, read_ptr, data_out);
        else passed++;
        total++;
        if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000)
            $display("FAIL async_reset_status: got %b expected 101000",
                     {empty, full, almost_empty, almost_full, overflow, underflow});
        else passed++;
        #2 reset = 1'b0;
        wr_en = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({count, data_out, underflow} !== {4'd0, 8'h00, 1'b1})
            $display("FAIL post_reset_empty: got count=%0d dout=%h unf=%b expected 0 00 1",
                     count, data_out, underflow);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_errors();
        test_flush();
        test_fwft();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
